mips32_mem_dump: RTL and testbench

Post-run memory readout engine for the pipe_mips32 core: after a program halts, or on command, it reads a contiguous range of data-memory words through a synchronous read port. It streams them out as a framed byte sequence over a valid/ready interface, toward a UART transmitter or a host debug link. It is the consumer-side counterpart to program/data loading: loaders write Mem before a run, this block reads results out after.

---
 rtl/mips32_dbg_pkg.sv | 22 ++
 rtl/mips32_mem_dump.sv | 154 +++++++++++++++
 tb/tb_mips32_mem_dump.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_dbg_pkg.sv
// Shared definitions for the pipe_mips32 debug memory-dump path.
// Holds the dump FSM state encoding, the default frame header byte and the
// frame byte-width constants so the host-link decoder can use the same values.
package mips32_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CNT  = 3'd2,
    ST_READ = 3'd3,
    ST_WAIT = 3'd4,
    ST_SEND = 3'd5,
    ST_CSUM = 3'd6
  } dump_state_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam int         BYTE_W           = 8;
  localparam int         WORD_W           = 32;
  localparam int         WORD_BYTES       = WORD_W / BYTE_W;
  localparam int         COUNT_W          = 8;

endpackage

// File: rtl/mips32_mem_dump.sv
// mips32_mem_dump: post-run data-memory readout engine.
// Reads word_count words starting at start_addr through a synchronous read
// port and streams them as a framed byte sequence:
//   HDR_BYTE, count, each word MSB-first, XOR checksum of all preceding bytes.
// Ports:
//   clk1, reset         clock, asynchronous active-high reset
//   start, halted       dump request (pulse) / HALTED flag (rising edge requests)
//   start_addr          first word address, sampled at request
//   word_count          number of words (0..255), sampled at request
//   mem_rd_en, mem_addr synchronous memory read strobe and word address
//   mem_rdata           read data, valid one cycle after mem_rd_en
//   tx_data, tx_valid   output byte stream (valid/ready)
//   tx_ready            sink ready
//   busy                request accepted and frame not yet fully accepted
//   done                one-cycle pulse after the checksum byte is accepted
module mips32_mem_dump
  import mips32_dbg_pkg::*;
#(
  parameter int         ADDR_W   = 10,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic               clk1,
  input  logic               reset,
  input  logic               start,
  input  logic               halted,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [WORD_W-1:0]  mem_rdata,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done
);

  localparam int BIDX_W = $clog2(WORD_BYTES);

  dump_state_t         state;
  logic                halted_q;
  logic [ADDR_W-1:0]   addr;
  logic [COUNT_W-1:0]  remaining;
  logic [BIDX_W-1:0]   byte_idx;
  logic [BYTE_W-1:0]   csum;
  logic [COUNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0]   shreg;

  logic req;
  logic accept;
  logic last_byte;

  // Decrement that holds at zero so the word counter can never wrap.
  function automatic logic [COUNT_W-1:0] sat_dec(input logic [COUNT_W-1:0] v);
    return (v == '0) ? '0 : v - COUNT_W'(1);
  endfunction

  // start and a halted rising edge in the same cycle merge into one request.
  assign req       = start | (halted & ~halted_q);
  assign accept    = tx_valid & tx_ready;
  assign last_byte = (byte_idx == BIDX_W'(WORD_BYTES - 1));

  assign busy      = (state != ST_IDLE);
  assign mem_rd_en = (state == ST_READ);
  assign mem_addr  = addr;
  assign tx_valid  = (state == ST_HDR) || (state == ST_CNT) ||
                     (state == ST_SEND) || (state == ST_CSUM);

  // tx_data is a pure function of state and held registers, so it stays
  // stable for as long as the sink stalls.
  always_comb begin
    tx_data = '0;
    case (state)
      ST_HDR:  tx_data = HDR_BYTE;
      ST_CNT:  tx_data = cnt_q;
      ST_SEND: tx_data = shreg[WORD_W-1 -: BYTE_W];
      ST_CSUM: tx_data = csum;
      default: tx_data = '0;
    endcase
  end

  // Control path: FSM, edge detector, address/remaining counters, checksum.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      halted_q  <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      csum      <= '0;
      done      <= 1'b0;
    end else begin
      halted_q <= halted;
      done     <= 1'b0;
      if (accept) begin
        csum <= csum ^ tx_data;
      end
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr      <= start_addr;
            remaining <= word_count;
            csum      <= '0;
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (tx_ready) state <= ST_CNT;
        end
        ST_CNT: begin
          if (tx_ready) state <= (remaining != '0) ? ST_READ : ST_CSUM;
        end
        ST_READ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          byte_idx <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            byte_idx <= byte_idx + BIDX_W'(1);
            if (last_byte) begin
              addr      <= addr + ADDR_W'(1);
              remaining <= sat_dec(remaining);
              state     <= (remaining > COUNT_W'(1)) ? ST_READ : ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (tx_ready) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data path: frame count byte and word shift register carry no reset; they
  // are only observed in states reached after being loaded.
  always_ff @(posedge clk1) begin
    if (state == ST_IDLE && req) begin
      cnt_q <= word_count;
    end
    if (state == ST_WAIT) begin
      shreg <= mem_rdata;
    end else if (state == ST_SEND && tx_ready) begin
      shreg <= {shreg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end
  end

endmodule

// File: tb/tb_mips32_mem_dump.sv
module tb_mips32_mem_dump;

  localparam int ADDR_W = 10;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              halted = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [7:0]        word_count = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              busy;
  logic              done;

  mips32_mem_dump #(.ADDR_W(ADDR_W), .HDR_BYTE(8'hA5)) dut (
    .clk1(clk1), .reset(reset), .start(start), .halted(halted),
    .start_addr(start_addr), .word_count(word_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  // Memory model with one-cycle read latency.
  logic [31:0] mem [MEM_N];
  always @(posedge clk1) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Sink readiness: always ready, or pseudo-random when bp_en is set.
  bit bp_en = 1'b0;
  always @(posedge clk1) begin
    #1;
    tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int compared = 0;
  int mismatched = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endfunction

  // Behavioural frame model: byte stream and read addresses derived from
  // the frame rules directly.
  logic [7:0]        mdl_q[$];
  logic [ADDR_W-1:0] mdl_addr_q[$];
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  function automatic void build_frame(int a, int n);
    logic [7:0]  x;
    logic [31:0] w;
    mdl_q.delete();
    mdl_addr_q.delete();
    mdl_q.push_back(8'hA5);
    mdl_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      mdl_addr_q.push_back(ADDR_W'((a + i) % MEM_N));
      w = mem[(a + i) % MEM_N];
      for (int b = 3; b >= 0; b--) mdl_q.push_back(w[b*8 +: 8]);
    end
    x = 8'h00;
    foreach (mdl_q[i]) x = x ^ mdl_q[i];
    mdl_q.push_back(x);
  endfunction

  // Per-cycle compare process.
  bit         chk_en = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = '0;
  int         acc_cnt = 0;
  int         rd_cnt = 0;
  int         done_cnt = 0;

  always @(negedge clk1) begin
    if (chk_en && !reset) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else chk("stream_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (mem_rd_en) begin
        rd_cnt++;
        if (exp_addr_q.size() == 0) chk("extra_read", 32'(mem_addr), 32'hFFFF_FFFF);
        else chk("read_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", 32'(busy), 32'd0);
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  int rd0, done0;

  task automatic issue_request(int a, int n, bit vs, bit vh);
    build_frame(a, n);
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    foreach (mdl_addr_q[i]) exp_addr_q.push_back(mdl_addr_q[i]);
    rd0 = rd_cnt;
    done0 = done_cnt;
    @(posedge clk1); #1;
    start_addr = ADDR_W'(a);
    word_count = 8'(n);
    start = vs;
    if (vh) halted = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    @(negedge clk1);
    chk("hdr_valid_cycle1", 32'(tx_valid), 32'd1);
    chk("busy_cycle1", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(int n, bit timing, bit mid_start);
    int k = 0;
    while (!done && k < 4000) begin
      @(negedge clk1);
      k++;
      if (mid_start && k == 5) start = 1'b1;
      if (mid_start && k == 6) start = 1'b0;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (timing) chk("hdr_to_csum_cycles", 32'(k), 32'(3 + 6 * n));
    @(negedge clk1);
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    chk("reads_left", 32'(exp_addr_q.size()), 32'd0);
    chk("read_count", 32'(rd_cnt - rd0), 32'(n));
    chk("done_count", 32'(done_cnt - done0), 32'd1);
  endtask

  task automatic idle_quiet(int cycles);
    int d0 = done_cnt;
    int a0 = acc_cnt;
    repeat (cycles) @(negedge clk1);
    chk("idle_no_done", 32'(done_cnt - d0), 32'd0);
    chk("idle_no_bytes", 32'(acc_cnt - a0), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
  endtask

  localparam logic [7:0] TWO_WORD [11] =
    '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h82, 8'h70};
  localparam logic [7:0] ZERO_WORD [3] = '{8'hA5, 8'h00, 8'hA5};

  initial begin
    int k;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[120]  = 32'd85;
    mem[121]  = 32'd130;
    mem[1023] = 32'h1234_5678;
    mem[0]    = 32'hDEAD_BEEF;

    // Model pins against hand-computed streams.
    build_frame(120, 2);
    chk("model_len_2w", 32'(mdl_q.size()), 32'd11);
    for (int i = 0; i < 11; i++) chk("model_2w_byte", 32'(mdl_q[i]), 32'(TWO_WORD[i]));
    build_frame(5, 0);
    chk("model_len_0w", 32'(mdl_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("model_0w_byte", 32'(ZERO_WORD[i]), 32'(mdl_q[i]));
    build_frame(1023, 2);
    chk("model_wrap_addr1", 32'(mdl_addr_q[1]), 32'd0);
    chk("model_wrap_csum", 32'(mdl_q[10]), 32'(8'hA5 ^ 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78
                                              ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF));

    // Reset values.
    repeat (3) @(negedge clk1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk1); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    idle_quiet(4);

    // Two-word dump with the sink always ready.
    issue_request(120, 2, 1'b1, 1'b0);
    wait_done(2, 1'b1, 1'b0);

    // Zero count.
    issue_request(300, 0, 1'b1, 1'b0);
    wait_done(0, 1'b1, 1'b0);

    // Backpressure.
    bp_en = 1'b1;
    issue_request(120, 2, 1'b1, 1'b0);
    wait_done(2, 1'b0, 1'b0);
    bp_en = 1'b0;

    // Address wrap.
    issue_request(1023, 2, 1'b1, 1'b0);
    wait_done(2, 1'b1, 1'b0);

    // halted rising edge triggers; start pulsed mid-frame is ignored.
    issue_request(120, 2, 1'b0, 1'b1);
    wait_done(2, 1'b1, 1'b1);
    idle_quiet(20);
    @(posedge clk1); #1;
    halted = 1'b0;
    idle_quiet(3);

    // start and halted edge together: one frame.
    issue_request(1023, 1, 1'b1, 1'b1);
    wait_done(1, 1'b1, 1'b0);
    idle_quiet(20);
    @(posedge clk1); #1;
    halted = 1'b0;

    // Reset during the second data byte.
    issue_request(120, 2, 1'b1, 1'b0);
    k = 0;
    while (acc_cnt < 0) k++;
    begin
      int a0 = acc_cnt - 1;
      k = 0;
      while (acc_cnt < a0 + 3 && k < 500) begin
        @(posedge clk1);
        k++;
      end
    end
    #2;
    chk("abort_point_valid", 32'(tx_valid), 32'd1);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_tx_data", 32'(tx_data), 32'd0);
    chk("abort_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk1); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    idle_quiet(5);
    issue_request(120, 2, 1'b1, 1'b0);
    wait_done(2, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "timeout");
  end

endmodule
